multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
- Next-generation main control for the RV32I core: a multi-cycle controller replacing the single-cycle opcode decoder.
- Sequences each instruction through fetch, decode, execute, memory and writeback states and drives the shared-ALU/shared-memory datapath.
- Adds JAL, a memory ready handshake, and an illegal-opcode trap.
- Sits between the instruction register (opcode, funct fields are decoded elsewhere by the ALU decoder) and the datapath muxes/enables.

Parameters:
- OPCODE_W, 7, opcode field width.
- ALUOP_W, 2, ALUOp width fed to the ALU decoder.
- IMMSRC_W, 3, ImmSrc width (I/S/B/J formats).
- SUPPORT_JAL, 1, 1 = decode JAL (7'b1101111); 0 = JAL is illegal.
- MEM_HANDSHAKE, 1, 1 = honour mem_ready; 0 = mem_ready treated as constant 1.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  OPCODE_W  opcode from the instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access requested.
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  memory address: 0 = PC, 1 = ALUOut.
- MemWrite  out  1  memory write enable.
- IRWrite  out  1  instruction register / OldPC enable.
- ResultSrc  out  2  result mux: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  out  2  ALU A: 00 = PC, 01 = OldPC, 10 = rs1.
- ALUSrcB  out  2  ALU B: 00 = rs2, 01 = ImmExt, 10 = constant 4.
- ALUOp  out  ALUOP_W  00 = add, 01 = subtract (branch), 10 = funct-decoded.
- ImmSrc  out  IMMSRC_W  immediate format: 000 = I, 001 = S, 010 = B, 011 = J.
- RegWrite  out  1  register file write enable.
- illegal_op  out  1  high while in TRAP.
- state_o  out  4  current state encoding, for debug and the bench.

Behaviour:

Reset and default outputs:
- rst is synchronous. While rst is high, the next state is FETCH, and PCWrite, MemWrite, IRWrite, RegWrite and mem_req are forced to 0.
- Every output not listed for a state below is 0.

Output style:
- Moore outputs, except two signals that are combinational on mem_ready and zero:
  - PCWrite = PCUpdate | (Branch & zero).
  - IRWrite is gated by mem_ready.
- ImmSrc is decoded combinationally from opcode in every state: lw/I-type → 000, sw → 001, beq → 010, jal → 011, other → 000.

States and transitions:
- FETCH: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10; IRWrite=mem_ready; PCUpdate=mem_ready. Go to DECODE when ready, else stay.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch/jump target into ALUOut). Next state by opcode:
  - lw/sw → MEMADR
  - R-type → EXECR
  - I-type → EXECI
  - beq → BEQ
  - jal → JAL (only if SUPPORT_JAL)
  - anything else → TRAP
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next: lw → MEMREAD, sw → MEMWRITE.
- MEMREAD: mem_req=1, AdrSrc=1, ResultSrc=00. Go to MEMWB on mem_ready, else stay.
- MEMWB: ResultSrc=01, RegWrite=1. Next: FETCH.
- MEMWRITE: mem_req=1, AdrSrc=1, ResultSrc=00. MemWrite=1 for the whole state; memory commits on the ready cycle. Go to FETCH on mem_ready.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next: ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next: ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Next: FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Next: FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Next: ALUWB (writes PC+4 to rd).
- TRAP: illegal_op=1, all enables 0. Held until rst.

Latency with mem_ready always 1:
- lw 5 cycles; sw 4; R, I and jal 4; beq 3.
- Each wait cycle adds 1 cycle to FETCH, MEMREAD or MEMWRITE.

Boundary conditions:
- mem_ready low in FETCH: no IRWrite and no PCWrite; all other FETCH outputs held stable.
- mem_ready high outside the three memory states: ignored.
- rst asserted in any state, including during a memory wait or in TRAP: next cycle is FETCH. An in-flight store is abandoned with MemWrite=0 from the reset cycle onward.
- opcode changing outside DECODE/MEMADR: no effect on state (IR is held by IRWrite).

Decomposition:
- Shared package riscv_ctrl_pkg holds:
  - opcode constants (lw, sw, R, I, beq, jal);
  - state encoding (4-bit; FETCH = 0, TRAP = 4'hF);
  - ResultSrc, ALUSrcA, ALUSrcB, ALUOp and ImmSrc encodings.
- One sub-module, instr_decoder (combinational), maps opcode to instruction class, ImmSrc and legality. The FSM uses it for DECODE branching and the ImmSrc output.

Test Plan:
- lw, mem_ready=1: states FETCH→DECODE→MEMADR→MEMREAD→MEMWB; RegWrite=1 and ResultSrc=01 only in cycle 5; 5 cycles total.
- sw with mem_ready held 0 for 2 cycles in MEMWRITE: MemWrite=1 for 3 cycles, then FETCH; RegWrite never asserted.
- beq with zero=1 in BEQ → PCWrite=1 in that cycle. Repeat with zero=0 → PCWrite=0. Both return to FETCH after 3 cycles.
- jal (SUPPORT_JAL=1): PCWrite=1 in JAL; RegWrite=1 with ResultSrc=00 in ALUWB. Rebuild with SUPPORT_JAL=0: DECODE→TRAP, illegal_op=1 held.
- Opcode 7'b1111111 → TRAP; stays there for 10 cycles regardless of mem_ready; rst=1 for one edge → state_o=FETCH, illegal_op=0.
- rst asserted in MEMREAD during a wait: next cycle state_o=0, RegWrite/MemWrite/IRWrite all 0. Fetch restarts with IRWrite only on mem_ready.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle controller: opcodes, FSM state
// encoding, datapath mux selects and the per-state Moore control word.
package riscv_ctrl_pkg;

  // Opcode values of the supported instruction groups
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  // Controller states; FETCH is the reset state and TRAP sits at the top code
  typedef enum logic [3:0] {
    S_FETCH    = 4'h0,
    S_DECODE   = 4'h1,
    S_MEMADR   = 4'h2,
    S_MEMREAD  = 4'h3,
    S_MEMWB    = 4'h4,
    S_MEMWRITE = 4'h5,
    S_EXECR    = 4'h6,
    S_EXECI    = 4'h7,
    S_ALUWB    = 4'h8,
    S_BEQ      = 4'h9,
    S_JAL      = 4'hA,
    S_TRAP     = 4'hF
  } state_e;

  // ResultSrc encodings
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALUSrcA encodings
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  // ALUSrcB encodings
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // ALUOp encodings
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ImmSrc encodings
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;

  // Instruction class produced by the opcode decoder
  typedef enum logic [2:0] {
    CLS_LOAD    = 3'd0,
    CLS_STORE   = 3'd1,
    CLS_RTYPE   = 3'd2,
    CLS_ITYPE   = 3'd3,
    CLS_BRANCH  = 3'd4,
    CLS_JAL     = 3'd5,
    CLS_ILLEGAL = 3'd6
  } instr_class_e;

  // Moore control word held in a register alongside the state.
  // fetch_en covers both the ready-gated IR load and the ready-gated PC+4
  // update of FETCH; pc_update is the unconditional PC load of JAL.
  typedef struct packed {
    logic       mem_req;
    logic       adr_src;
    logic       mem_write;
    logic       fetch_en;
    logic       pc_update;
    logic       branch;
    logic       reg_write;
    logic       illegal;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  // Control word for a given state; anything not set stays 0
  function automatic ctrl_t state_ctrl(input state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_req    = 1'b1;
        c.fetch_en   = 1'b1;
        c.alu_src_a  = SRCA_PC;
        c.alu_src_b  = SRCB_FOUR;
        c.alu_op     = ALUOP_ADD;
        c.result_src = RES_ALURESULT;
      end
      S_DECODE: begin
        c.alu_src_a = SRCA_OLDPC;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      S_MEMREAD: begin
        c.mem_req    = 1'b1;
        c.adr_src    = 1'b1;
        c.result_src = RES_ALUOUT;
      end
      S_MEMWB: begin
        c.result_src = RES_DATA;
        c.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        c.mem_req    = 1'b1;
        c.adr_src    = 1'b1;
        c.mem_write  = 1'b1;
        c.result_src = RES_ALUOUT;
      end
      S_EXECR: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_RS2;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        c.result_src = RES_ALUOUT;
        c.reg_write  = 1'b1;
      end
      S_BEQ: begin
        c.alu_src_a  = SRCA_RS1;
        c.alu_src_b  = SRCB_RS2;
        c.alu_op     = ALUOP_SUB;
        c.result_src = RES_ALUOUT;
        c.branch     = 1'b1;
      end
      S_JAL: begin
        c.alu_src_a  = SRCA_OLDPC;
        c.alu_src_b  = SRCB_FOUR;
        c.alu_op     = ALUOP_ADD;
        c.result_src = RES_ALUOUT;
        c.pc_update  = 1'b1;
      end
      S_TRAP: begin
        c.illegal = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational opcode decoder: instruction class, immediate format and
// legality for the multi-cycle controller.
module instr_decoder
  import riscv_ctrl_pkg::*;
#(
  parameter int OPCODE_W    = 7,
  parameter int IMMSRC_W    = 3,
  parameter bit SUPPORT_JAL = 1'b1
) (
  input  logic [OPCODE_W-1:0] opcode_i,
  output instr_class_e        cls_o,
  output logic [IMMSRC_W-1:0] imm_src_o,
  output logic                legal_o
);

  logic [2:0] imm_raw;

  // Classify the opcode; JAL is only legal when the core supports it
  always_comb begin
    cls_o   = CLS_ILLEGAL;
    imm_raw = IMM_I;
    case (opcode_i)
      OPCODE_W'(OP_LW): begin
        cls_o   = CLS_LOAD;
        imm_raw = IMM_I;
      end
      OPCODE_W'(OP_SW): begin
        cls_o   = CLS_STORE;
        imm_raw = IMM_S;
      end
      OPCODE_W'(OP_RTYPE): begin
        cls_o   = CLS_RTYPE;
        imm_raw = IMM_I;
      end
      OPCODE_W'(OP_ITYPE): begin
        cls_o   = CLS_ITYPE;
        imm_raw = IMM_I;
      end
      OPCODE_W'(OP_BEQ): begin
        cls_o   = CLS_BRANCH;
        imm_raw = IMM_B;
      end
      OPCODE_W'(OP_JAL): begin
        cls_o   = SUPPORT_JAL ? CLS_JAL : CLS_ILLEGAL;
        imm_raw = IMM_J;
      end
      default: begin
        cls_o   = CLS_ILLEGAL;
        imm_raw = IMM_I;
      end
    endcase
  end

  assign legal_o   = (cls_o != CLS_ILLEGAL);
  assign imm_src_o = IMMSRC_W'(imm_raw);

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle main controller for the RV32I core. Steps each instruction
// through fetch/decode/execute/memory/writeback and drives the shared
// ALU / shared memory datapath. Moore outputs come from a control word
// registered together with the state; only PCWrite and IRWrite look at
// mem_ready/zero combinationally, and all enables are killed while rst is high.
module multicycle_control_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int OPCODE_W      = 7,
  parameter int ALUOP_W       = 2,
  parameter int IMMSRC_W      = 3,
  parameter bit SUPPORT_JAL   = 1'b1,
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                PCWrite,
  output logic                AdrSrc,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic [1:0]          ResultSrc,
  output logic [1:0]          ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic [IMMSRC_W-1:0] ImmSrc,
  output logic                RegWrite,
  output logic                illegal_op,
  output logic [3:0]          state_o
);

  state_e       state_q;
  state_e       state_d;
  ctrl_t        ctrl_q;
  instr_class_e cls;
  logic         legal;
  logic         ready_eff;
  logic         en_ok;

  // Without a handshake the memory is assumed to complete every access at once
  assign ready_eff = MEM_HANDSHAKE ? mem_ready : 1'b1;

  instr_decoder #(
    .OPCODE_W   (OPCODE_W),
    .IMMSRC_W   (IMMSRC_W),
    .SUPPORT_JAL(SUPPORT_JAL)
  ) u_decoder (
    .opcode_i (opcode),
    .cls_o    (cls),
    .imm_src_o(ImmSrc),
    .legal_o  (legal)
  );

  // Next-state selection; opcode only matters in DECODE and MEMADR
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (ready_eff) state_d = S_DECODE;
      S_DECODE: begin
        if (!legal) begin
          state_d = S_TRAP;
        end else begin
          case (cls)
            CLS_LOAD,
            CLS_STORE:  state_d = S_MEMADR;
            CLS_RTYPE:  state_d = S_EXECR;
            CLS_ITYPE:  state_d = S_EXECI;
            CLS_BRANCH: state_d = S_BEQ;
            CLS_JAL:    state_d = S_JAL;
            default:    state_d = S_TRAP;
          endcase
        end
      end
      S_MEMADR:   state_d = (cls == CLS_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (ready_eff) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (ready_eff) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_TRAP:     state_d = S_TRAP;
      // Unused encodings are treated as a fault and parked in TRAP
      default:    state_d = S_TRAP;
    endcase
  end

  // State register plus the Moore control word of the state being entered
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      ctrl_q  <= state_ctrl(S_FETCH);
    end else begin
      state_q <= state_d;
      ctrl_q  <= state_ctrl(state_d);
    end
  end

  // Enables drop in the reset cycle itself so an in-flight store is abandoned
  assign en_ok = ~rst;

  assign mem_req  = en_ok & ctrl_q.mem_req;
  assign MemWrite = en_ok & ctrl_q.mem_write;
  assign RegWrite = en_ok & ctrl_q.reg_write;
  assign IRWrite  = en_ok & ctrl_q.fetch_en & ready_eff;
  assign PCWrite  = en_ok & ((ctrl_q.fetch_en & ready_eff)
                             | ctrl_q.pc_update
                             | (ctrl_q.branch & zero));

  assign AdrSrc     = ctrl_q.adr_src;
  assign ResultSrc  = ctrl_q.result_src;
  assign ALUSrcA    = ctrl_q.alu_src_a;
  assign ALUSrcB    = ctrl_q.alu_src_b;
  assign ALUOp      = ALUOP_W'(ctrl_q.alu_op);
  assign illegal_op = ctrl_q.illegal;
  assign state_o    = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: one task per scenario, with
// hand-computed expected states and control values.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;

  logic       mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_op;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [2:0] ImmSrc;
  logic [3:0] state_o;

  logic       j0_mem_req, j0_PCWrite, j0_AdrSrc, j0_MemWrite, j0_IRWrite, j0_RegWrite, j0_illegal_op;
  logic [1:0] j0_ResultSrc, j0_ALUSrcA, j0_ALUSrcB, j0_ALUOp;
  logic [2:0] j0_ImmSrc;
  logic [3:0] j0_state_o;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] RTY  = 7'b0110011;
  localparam logic [6:0] ITY  = 7'b0010011;
  localparam logic [6:0] BEQ  = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] BAD  = 7'b1111111;

  always #5 clk = ~clk;

  multicycle_control_fsm dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .ImmSrc(ImmSrc), .RegWrite(RegWrite), .illegal_op(illegal_op),
    .state_o(state_o)
  );

  multicycle_control_fsm #(.SUPPORT_JAL(1'b0)) dut_nojal (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(j0_mem_req), .PCWrite(j0_PCWrite), .AdrSrc(j0_AdrSrc), .MemWrite(j0_MemWrite),
    .IRWrite(j0_IRWrite), .ResultSrc(j0_ResultSrc), .ALUSrcA(j0_ALUSrcA), .ALUSrcB(j0_ALUSrcB),
    .ALUOp(j0_ALUOp), .ImmSrc(j0_ImmSrc), .RegWrite(j0_RegWrite), .illegal_op(j0_illegal_op),
    .state_o(j0_state_o)
  );

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_ready = 1'b1; zero = 1'b1; opcode = LW;
    tick();
    checks++; if (PCWrite !== 1'b0) begin errors++; $display("FAIL reset_pcwrite: got %b want 0", PCWrite); end
    checks++; if (IRWrite !== 1'b0) begin errors++; $display("FAIL reset_irwrite: got %b want 0", IRWrite); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_memreq: got %b want 0", mem_req); end
    rst = 1'b0;
    #1;
    checks++; if (state_o !== 4'h0) begin errors++; $display("FAIL reset_state: got %h want 0", state_o); end
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL fetch_memreq: got %b want 1", mem_req); end
    checks++; if (IRWrite !== 1'b1 || PCWrite !== 1'b1) begin errors++; $display("FAIL fetch_enables: got IR=%b PC=%b want 1 1", IRWrite, PCWrite); end
    checks++; if (ALUSrcB !== 2'b10 || ResultSrc !== 2'b10 || AdrSrc !== 1'b0 || ALUSrcA !== 2'b00) begin
      errors++; $display("FAIL fetch_muxes: got B=%b Res=%b Adr=%b A=%b want 10 10 0 00", ALUSrcB, ResultSrc, AdrSrc, ALUSrcA);
    end
    $display("reset: done");
  endtask

  task automatic test_lw();
    logic [3:0] exp_st [5];
    logic [1:0] exp_rs [5];
    exp_st = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4};
    exp_rs = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b01};
    opcode = LW; mem_ready = 1'b1; zero = 1'b0;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      checks++; if (state_o !== exp_st[c]) begin errors++; $display("FAIL lw_state c%0d: got %h want %h", c, state_o, exp_st[c]); end
      checks++; if (RegWrite !== (c == 4)) begin errors++; $display("FAIL lw_regwrite c%0d: got %b want %b", c, RegWrite, (c == 4)); end
      checks++; if (ResultSrc !== exp_rs[c]) begin errors++; $display("FAIL lw_resultsrc c%0d: got %b want %b", c, ResultSrc, exp_rs[c]); end
      if (c == 3) begin
        checks++; if (AdrSrc !== 1'b1 || mem_req !== 1'b1) begin errors++; $display("FAIL lw_memread: got Adr=%b req=%b want 1 1", AdrSrc, mem_req); end
      end
      tick();
    end
    checks++; if (state_o !== 4'h0) begin errors++; $display("FAIL lw_return: got %h want 0", state_o); end
    $display("lw: 5-cycle sequence done");
  endtask

  task automatic test_sw();
    opcode = SW; mem_ready = 1'b1; zero = 1'b0;
    do_reset();
    tick();
    checks++; if (state_o !== 4'h1) begin errors++; $display("FAIL sw_decode: got %h want 1", state_o); end
    tick();
    checks++; if (state_o !== 4'h2 || MemWrite !== 1'b0) begin errors++; $display("FAIL sw_memadr: got st=%h mw=%b want 2 0", state_o, MemWrite); end
    mem_ready = 1'b0;
    tick();
    for (int w = 0; w < 3; w++) begin
      if (w == 2) mem_ready = 1'b1;
      #1;
      checks++; if (state_o !== 4'h5 || MemWrite !== 1'b1) begin errors++; $display("FAIL sw_memwrite w%0d: got st=%h mw=%b want 5 1", w, state_o, MemWrite); end
      checks++; if (RegWrite !== 1'b0 || AdrSrc !== 1'b1) begin errors++; $display("FAIL sw_ctrl w%0d: got rw=%b adr=%b want 0 1", w, RegWrite, AdrSrc); end
      tick();
    end
    checks++; if (state_o !== 4'h0 || MemWrite !== 1'b0) begin errors++; $display("FAIL sw_return: got st=%h mw=%b want 0 0", state_o, MemWrite); end
    $display("sw: 2 wait cycles, store committed");
  endtask

  task automatic test_store_abort();
    opcode = SW; mem_ready = 1'b1;
    do_reset();
    tick(); tick();
    mem_ready = 1'b0;
    tick();
    checks++; if (MemWrite !== 1'b1) begin errors++; $display("FAIL abort_pre: got mw=%b want 1", MemWrite); end
    rst = 1'b1;
    #1;
    checks++; if (MemWrite !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL abort_rstcycle: got mw=%b req=%b want 0 0", MemWrite, mem_req); end
    tick();
    rst = 1'b0;
    #1;
    checks++; if (state_o !== 4'h0 || MemWrite !== 1'b0) begin errors++; $display("FAIL abort_after: got st=%h mw=%b want 0 0", state_o, MemWrite); end
    mem_ready = 1'b1;
    $display("sw: store abandoned by reset");
  endtask

  task automatic test_beq();
    for (int z = 1; z >= 0; z--) begin
      opcode = BEQ; mem_ready = 1'b1; zero = z[0];
      do_reset();
      tick();
      checks++; if (state_o !== 4'h1 || PCWrite !== 1'b0) begin errors++; $display("FAIL beq_decode z%0d: got st=%h pcw=%b want 1 0", z, state_o, PCWrite); end
      tick();
      checks++; if (state_o !== 4'h9 || ALUOp !== 2'b01) begin errors++; $display("FAIL beq_state z%0d: got st=%h op=%b want 9 01", z, state_o, ALUOp); end
      checks++; if (PCWrite !== z[0]) begin errors++; $display("FAIL beq_pcwrite z%0d: got %b want %b", z, PCWrite, z[0]); end
      tick();
      checks++; if (state_o !== 4'h0) begin errors++; $display("FAIL beq_return z%0d: got %h want 0", z, state_o); end
      $display("beq: zero=%0d done", z);
    end
    zero = 1'b0;
  endtask

  task automatic test_jal();
    opcode = JAL; mem_ready = 1'b1; zero = 1'b0;
    do_reset();
    tick(); tick();
    checks++; if (state_o !== 4'hA || PCWrite !== 1'b1) begin errors++; $display("FAIL jal_state: got st=%h pcw=%b want a 1", state_o, PCWrite); end
    checks++; if (ALUSrcA !== 2'b01 || ALUSrcB !== 2'b10) begin errors++; $display("FAIL jal_muxes: got A=%b B=%b want 01 10", ALUSrcA, ALUSrcB); end
    checks++; if (j0_state_o !== 4'hF || j0_illegal_op !== 1'b1) begin errors++; $display("FAIL nojal_trap: got st=%h ill=%b want f 1", j0_state_o, j0_illegal_op); end
    tick();
    checks++; if (state_o !== 4'h8 || RegWrite !== 1'b1 || ResultSrc !== 2'b00 || PCWrite !== 1'b0) begin
      errors++; $display("FAIL jal_aluwb: got st=%h rw=%b res=%b pcw=%b want 8 1 00 0", state_o, RegWrite, ResultSrc, PCWrite);
    end
    tick();
    checks++; if (state_o !== 4'h0) begin errors++; $display("FAIL jal_return: got %h want 0", state_o); end
    tick(); tick();
    checks++; if (j0_state_o !== 4'hF || j0_illegal_op !== 1'b1 || j0_RegWrite !== 1'b0) begin
      errors++; $display("FAIL nojal_held: got st=%h ill=%b rw=%b want f 1 0", j0_state_o, j0_illegal_op, j0_RegWrite);
    end
    $display("jal: supported and unsupported builds done");
  endtask

  task automatic test_trap();
    opcode = BAD; mem_ready = 1'b1;
    do_reset();
    tick(); tick();
    for (int i = 0; i < 10; i++) begin
      mem_ready = i[0];
      opcode = (i < 5) ? LW : SW;
      #1;
      checks++; if (state_o !== 4'hF || illegal_op !== 1'b1) begin errors++; $display("FAIL trap_hold i%0d: got st=%h ill=%b want f 1", i, state_o, illegal_op); end
      checks++; if (mem_req !== 1'b0 || PCWrite !== 1'b0 || IRWrite !== 1'b0) begin
        errors++; $display("FAIL trap_enables i%0d: got req=%b pcw=%b irw=%b want 0 0 0", i, mem_req, PCWrite, IRWrite);
      end
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++; if (state_o !== 4'h0 || illegal_op !== 1'b0) begin errors++; $display("FAIL trap_exit: got st=%h ill=%b want 0 0", state_o, illegal_op); end
    $display("trap: held 10 cycles, cleared by reset");
  endtask

  task automatic test_fetch_wait_rtype();
    opcode = RTY; mem_ready = 1'b0; zero = 1'b0;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      checks++; if (state_o !== 4'h0 || IRWrite !== 1'b0 || PCWrite !== 1'b0) begin
        errors++; $display("FAIL fetchwait_en i%0d: got st=%h irw=%b pcw=%b want 0 0 0", i, state_o, IRWrite, PCWrite);
      end
      checks++; if (mem_req !== 1'b1 || ALUSrcB !== 2'b10 || ResultSrc !== 2'b10) begin
        errors++; $display("FAIL fetchwait_hold i%0d: got req=%b B=%b res=%b want 1 10 10", i, mem_req, ALUSrcB, ResultSrc);
      end
      tick();
    end
    mem_ready = 1'b1;
    #1;
    checks++; if (IRWrite !== 1'b1 || PCWrite !== 1'b1) begin errors++; $display("FAIL fetchwait_go: got irw=%b pcw=%b want 1 1", IRWrite, PCWrite); end
    tick();
    mem_ready = 1'b0;
    tick();
    checks++; if (state_o !== 4'h6 || ALUOp !== 2'b10 || ALUSrcA !== 2'b10 || ALUSrcB !== 2'b00) begin
      errors++; $display("FAIL rtype_exec: got st=%h op=%b A=%b B=%b want 6 10 10 00", state_o, ALUOp, ALUSrcA, ALUSrcB);
    end
    tick();
    checks++; if (state_o !== 4'h8 || RegWrite !== 1'b1) begin errors++; $display("FAIL rtype_wb: got st=%h rw=%b want 8 1", state_o, RegWrite); end
    tick();
    checks++; if (state_o !== 4'h0) begin errors++; $display("FAIL rtype_return: got %h want 0", state_o); end
    $display("rtype: fetch wait and execute done");
  endtask

  task automatic test_itype();
    opcode = ITY; mem_ready = 1'b1;
    do_reset();
    tick(); tick();
    checks++; if (state_o !== 4'h7 || ALUSrcB !== 2'b01 || ALUOp !== 2'b10) begin
      errors++; $display("FAIL itype_exec: got st=%h B=%b op=%b want 7 01 10", state_o, ALUSrcB, ALUOp);
    end
    tick();
    checks++; if (state_o !== 4'h8) begin errors++; $display("FAIL itype_wb: got %h want 8", state_o); end
    tick();
    $display("itype: done");
  endtask

  task automatic test_immsrc();
    logic [6:0] ops [7];
    logic [2:0] exp_imm [7];
    ops     = '{LW, ITY, SW, BEQ, JAL, RTY, BAD};
    exp_imm = '{3'b000, 3'b000, 3'b001, 3'b010, 3'b011, 3'b000, 3'b000};
    for (int i = 0; i < 7; i++) begin
      opcode = ops[i];
      #1;
      checks++; if (ImmSrc !== exp_imm[i]) begin errors++; $display("FAIL immsrc op=%b: got %b want %b", ops[i], ImmSrc, exp_imm[i]); end
    end
    $display("immsrc: table done");
  endtask

  task automatic test_reset_in_memread();
    opcode = LW; mem_ready = 1'b1;
    do_reset();
    tick(); tick();
    mem_ready = 1'b0;
    tick(); tick();
    checks++; if (state_o !== 4'h3) begin errors++; $display("FAIL memread_wait: got %h want 3", state_o); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++; if (state_o !== 4'h0) begin errors++; $display("FAIL memread_rst_state: got %h want 0", state_o); end
    checks++; if (RegWrite !== 1'b0 || MemWrite !== 1'b0 || IRWrite !== 1'b0) begin
      errors++; $display("FAIL memread_rst_en: got rw=%b mw=%b irw=%b want 0 0 0", RegWrite, MemWrite, IRWrite);
    end
    mem_ready = 1'b1;
    #1;
    checks++; if (IRWrite !== 1'b1) begin errors++; $display("FAIL memread_refetch: got irw=%b want 1", IRWrite); end
    tick();
    $display("memread: reset during wait done");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; opcode = LW; zero = 1'b0; mem_ready = 1'b1;
    test_reset();
    test_lw();
    test_sw();
    test_store_abort();
    test_beq();
    test_jal();
    test_trap();
    test_fetch_wait_rtype();
    test_itype();
    test_immsrc();
    test_reset_in_memread();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
